flag_cond_unit: RTL and testbench
=================================

Name: flag_cond_unit

Overview:
- Consumer end of the NZCV flag interface.
- Holds the architectural flag register, which is written by the ALU flag-setting stage.
- Tracks in-flight flag writers (instructions with S=1 that have issued but whose flags are not yet written). Stalls conditional instructions until flags are current.
- Evaluates the 4-bit condition code of each instruction against the flags. Returns pass/fail through a registered valid/ready response.

Parameters:
- TAG_W, 4, width of the instruction tag carried from request to response.
- PEND_W, 3, width of the pending-writer counter. Maximum outstanding writers = 2^PEND_W - 1.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- flag_alloc  input  1  an S=1 instruction issued; a flag write will follow
- alloc_ready  output  1  pending counter not saturated
- flag_wr_valid  input  1  flag write from the ALU this cycle
- flag_wr_data  input  4  new flags, bit order {N,Z,C,V} = [3:0]
- req_valid  input  1  condition request valid
- req_ready  output  1  request accepted this cycle when req_valid is also high
- req_cond  input  4  condition code
- req_tag  input  TAG_W  instruction tag
- rsp_valid  output  1  response valid
- rsp_ready  input  1  downstream accepts response
- rsp_pass  output  1  condition true
- rsp_tag  output  TAG_W  tag of the accepted request
- flags  output  4  current flag register
- underflow_err  output  1  sticky error: flag write arrived with no pending writer

Behaviour:
- Reset values: flags=4'b0000, pend_cnt=0, rsp_valid=0, rsp_pass=0, rsp_tag=0, underflow_err=0.
- Flag register:
  - Loads flag_wr_data on every cycle where flag_wr_valid=1.
  - The new value is visible on flags the following cycle.
- Pending counter, next value:
  - alloc only: pend_cnt+1.
  - write only with pend_cnt>0: pend_cnt-1.
  - alloc and write in the same cycle: unchanged.
  - write with pend_cnt=0 and no alloc: counter stays 0, flags are still written, underflow_err is set. underflow_err clears only on rst.
- Saturation:
  - alloc_ready = (pend_cnt != max).
  - An alloc when alloc_ready=0 is ignored; the counter does not wrap.
- stall = (pend_cnt != 0).
- req_ready = !stall && (!rsp_valid || rsp_ready).
- On accept (req_valid && req_ready):
  - rsp_pass is evaluated from the registered flags.
  - rsp_pass and rsp_tag are registered; rsp_valid=1 the next cycle (latency 1).
- Response buffer:
  - Single entry; holds rsp_pass and rsp_tag stable while rsp_valid && !rsp_ready.
  - Clears when rsp_ready=1 and no new accept occurs.
  - Back-to-back accepts give one response per cycle when rsp_ready=1.
- Condition table (N,Z,C,V):
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - 10 GE: N==V
  - 11 LT: N!=V
  - 12 GT: !Z&(N==V)
  - 13 LE: Z|(N!=V)
  - 14 AL: 1
  - 15 NV: 0
- AL and NV requests stall like any other condition. The unit has no per-code exemption.
- Reset mid-operation: pending writers and the buffered response are discarded. Inputs on the reset cycle are ignored.

Optional Feature:
- FLAG_BYPASS_EN
- Defined:
  - When flag_wr_valid=1, pend_cnt=1 and flag_alloc=0, the request is not stalled.
  - Its condition is evaluated from flag_wr_data in the same cycle.
  - Response latency is still 1 cycle.
- Undefined:
  - Requests wait until pend_cnt reaches 0.
  - They are evaluated from the registered flags one cycle after the final write, giving one extra bubble.

Decomposition:
- Shared package alu_pkg:
  - Flag index constants: FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - The 16 condition-code constants (COND_EQ through COND_NV).
- Sub-module cond_eval:
  - Purely combinational.
  - Inputs: flags[3:0] and cond[3:0]. Output: pass.
  - Reusable by the branch unit.

Test Plan:
- Reset, then req_cond=0 (EQ) with req_tag=3 -> req_ready=1; next cycle rsp_valid=1, rsp_pass=0, rsp_tag=3.
- flag_alloc, then two idle cycles, then flag_wr_valid with data 4'b0100; EQ request held from the alloc cycle onward -> req_ready=0 until pend_cnt=0; rsp_pass=1. With FLAG_BYPASS_EN, the request is accepted in the write cycle.
- Sweep all 16 cond values × all 16 flag values -> rsp_pass matches the table. Examples: GT with 4'b1001 -> 1; LE with 4'b1000 -> 1.
- Issue 7 allocs (PEND_W=3) -> alloc_ready=0; an 8th alloc is ignored; 7 writes bring pend_cnt back to 0; a simultaneous alloc+write leaves the count unchanged.
- rsp_ready=0 for 3 cycles with a request pending -> rsp_pass and rsp_tag stay stable and req_ready=0; when rsp_ready=1, the next request is accepted the same cycle.
- flag_wr_valid with pend_cnt=0 -> flags updated and underflow_err=1; it remains 1 until rst, and rst mid-stall clears pend_cnt and rsp_valid.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//
// Purpose:
//   Shared definitions for the NZCV flag path. The ALU flag-setting stage, the
//   flag/condition unit and the branch unit all use these definitions, so the
//   bit positions and condition encodings have a single home.
//
// Contents:
//   FLAG_N/FLAG_Z/FLAG_C/FLAG_V  bit positions inside a 4-bit {N,Z,C,V} word
//   cond_e                       the 16 architectural condition codes
//   nzcv_t                       packed view of a flag word
//   pack_nzcv()                  build a flag word from four separate bits
// -----------------------------------------------------------------------------
package alu_pkg;

    // Bit positions of the flags inside a 4-bit flag word.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FLAGS_W = 4;
    localparam int COND_W  = 4;

    // Condition codes. Odd codes are the logical inverse of the even code
    // just below them.
    typedef enum logic [COND_W-1:0] {
        COND_EQ = 4'd0,   // Z
        COND_NE = 4'd1,   // !Z
        COND_CS = 4'd2,   // C
        COND_CC = 4'd3,   // !C
        COND_MI = 4'd4,   // N
        COND_PL = 4'd5,   // !N
        COND_VS = 4'd6,   // V
        COND_VC = 4'd7,   // !V
        COND_HI = 4'd8,   // C & !Z
        COND_LS = 4'd9,   // !C | Z
        COND_GE = 4'd10,  // N == V
        COND_LT = 4'd11,  // N != V
        COND_GT = 4'd12,  // !Z & (N == V)
        COND_LE = 4'd13,  // Z | (N != V)
        COND_AL = 4'd14,  // always
        COND_NV = 4'd15   // never
    } cond_e;

    // Packed view whose field order matches FLAG_N..FLAG_V.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    // Assemble a flag word from individual flag bits.
    function automatic logic [FLAGS_W-1:0] pack_nzcv(
        input logic n,
        input logic z,
        input logic c,
        input logic v
    );
        nzcv_t f;
        f.n = n;
        f.z = z;
        f.c = c;
        f.v = v;
        return f;
    endfunction

endpackage : alu_pkg

// File: rtl/cond_eval.sv
// -----------------------------------------------------------------------------
// cond_eval
//
// Purpose:
//   Purely combinational evaluation of a 4-bit condition code against a
//   4-bit NZCV flag word. It has no state, so the branch unit can instantiate
//   it unchanged.
//
// Ports:
//   flags [3:0]  in   flag word, {N,Z,C,V} = [3:0]
//   cond  [3:0]  in   condition code (see alu_pkg::cond_e)
//   pass         out  1 when the condition holds for the given flags
// -----------------------------------------------------------------------------
module cond_eval
    import alu_pkg::*;
(
    input  logic [FLAGS_W-1:0] flags,
    input  logic [COND_W-1:0]  cond,
    output logic               pass
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        // NOTE: assigning a default before the case keeps this block purely
        // combinational even if an arm is later removed; no latch can form.
        pass = 1'b0;
        case (cond_e'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
        endcase
    end

endmodule : cond_eval

// File: rtl/flag_cond_unit.sv
// -----------------------------------------------------------------------------
// flag_cond_unit
//
// Purpose:
//   Consumer end of the NZCV flag interface. Holds the architectural flag
//   register, counts in-flight flag writers (S=1 instructions issued but not
//   yet written back), stalls condition requests while any writer is
//   outstanding, and returns pass/fail for each accepted request through a
//   single-entry registered valid/ready response buffer.
//
// Configuration:
//   FLAG_BYPASS_EN  when defined, a request arriving in the cycle of the last
//                   outstanding flag write (pend_cnt==1, no new alloc) is not
//                   stalled and is evaluated directly from flag_wr_data.
//                   When undefined, requests wait for pend_cnt==0 and use the
//                   registered flags, one bubble later.
//
// Parameters:
//   TAG_W   width of the instruction tag carried request -> response
//   PEND_W  width of the pending-writer counter (max 2**PEND_W-1 writers)
//
// Ports:
//   clk            in   clock
//   rst            in   synchronous active-high reset
//   flag_alloc     in   an S=1 instruction issued; a flag write will follow
//   alloc_ready    out  pending counter not saturated
//   flag_wr_valid  in   flag write from the ALU this cycle
//   flag_wr_data   in   new flags {N,Z,C,V}
//   req_valid      in   condition request valid
//   req_ready      out  request accepted this cycle when req_valid is high
//   req_cond       in   condition code
//   req_tag        in   instruction tag
//   rsp_valid      out  response valid
//   rsp_ready      in   downstream accepts response
//   rsp_pass       out  condition true
//   rsp_tag        out  tag of the accepted request
//   flags          out  current flag register
//   underflow_err  out  sticky: flag write arrived with no pending writer
// -----------------------------------------------------------------------------
module flag_cond_unit
    import alu_pkg::*;
#(
    parameter int TAG_W  = 4,
    parameter int PEND_W = 3
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               flag_alloc,
    output logic               alloc_ready,

    input  logic               flag_wr_valid,
    input  logic [FLAGS_W-1:0] flag_wr_data,

    input  logic               req_valid,
    output logic               req_ready,
    input  logic [COND_W-1:0]  req_cond,
    input  logic [TAG_W-1:0]   req_tag,

    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_pass,
    output logic [TAG_W-1:0]   rsp_tag,

    output logic [FLAGS_W-1:0] flags,
    output logic               underflow_err
);

    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    localparam logic [PEND_W-1:0] PEND_ZERO = '0;
    localparam logic [PEND_W-1:0] PEND_ONE  = {{(PEND_W-1){1'b0}}, 1'b1};

    logic [PEND_W-1:0]  pend_cnt;
    logic               alloc_ok;
    logic               bypass;
    logic               stall;
    logic               accept;
    logic [FLAGS_W-1:0] eval_flags;
    logic               eval_pass;

    // -------------------------------------------------------------------------
    // Handshake and stall logic
    // -------------------------------------------------------------------------
    assign alloc_ready = (pend_cnt != PEND_MAX);

    // An alloc against a saturated counter is dropped rather than wrapping.
    assign alloc_ok = flag_alloc && alloc_ready;

`ifdef FLAG_BYPASS_EN
    // The write landing this cycle retires the only outstanding writer and
    // no new writer is being issued, so flag_wr_data is already the value
    // the request must see.
    assign bypass     = flag_wr_valid && (pend_cnt == PEND_ONE) && !flag_alloc;
    assign eval_flags = bypass ? flag_wr_data : flags;
`else
    assign bypass     = 1'b0;
    assign eval_flags = flags;
`endif

    assign stall     = (pend_cnt != PEND_ZERO) && !bypass;
    assign req_ready = !stall && (!rsp_valid || rsp_ready);
    assign accept    = req_valid && req_ready;

    cond_eval u_cond_eval (
        .flags (eval_flags),
        .cond  (req_cond),
        .pass  (eval_pass)
    );

    // -------------------------------------------------------------------------
    // Pending-writer counter and sticky underflow flag
    // -------------------------------------------------------------------------
    // NOTE: all state in this module is updated with non-blocking assignments
    // so every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_cnt      <= PEND_ZERO;
            underflow_err <= 1'b0;
        end else begin
            case ({alloc_ok, flag_wr_valid})
                2'b10: pend_cnt <= pend_cnt + PEND_ONE;
                2'b01: begin
                    if (pend_cnt != PEND_ZERO) begin
                        pend_cnt <= pend_cnt - PEND_ONE;
                    end else begin
                        // Unmatched write: counter stays at zero, error sticks.
                        underflow_err <= 1'b1;
                    end
                end
                // Alloc and write cancel out; idle leaves the count alone.
                default: pend_cnt <= pend_cnt;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Architectural flag register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= '0;
        end else if (flag_wr_valid) begin
            flags <= flag_wr_data;
        end
    end

    // -------------------------------------------------------------------------
    // Single-entry response buffer
    // -------------------------------------------------------------------------
    // req_ready already folds in "buffer empty or draining", so an accept
    // can always overwrite the entry; otherwise the entry holds until
    // rsp_ready drains it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_pass  <= 1'b0;
            rsp_tag   <= '0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_pass  <= eval_pass;
            rsp_tag   <= req_tag;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule : flag_cond_unit

// File: tb/tb_flag_cond_unit.sv
// -----------------------------------------------------------------------------
// tb_flag_cond_unit
//
// Self-checking bench for flag_cond_unit. A behavioural model tracks flags,
// the number of outstanding writers, the response entry and the sticky error.
// Conditions are evaluated as 8 base predicates where the odd code inverts
// the even one. Inputs are driven 1 time unit after the rising edge;
// combinational outputs are checked before the next edge and registered
// outputs 1 unit after it.
// -----------------------------------------------------------------------------
module tb_flag_cond_unit;

    localparam int TAG_W    = 4;
    localparam int PEND_W   = 3;
    localparam int PEND_MAX = (1 << PEND_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             flag_alloc;
    logic             alloc_ready;
    logic             flag_wr_valid;
    logic [3:0]       flag_wr_data;
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_cond;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_pass;
    logic [TAG_W-1:0] rsp_tag;
    logic [3:0]       flags;
    logic             underflow_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [3:0]       m_flags;
    int               m_cnt;
    logic             m_rv;
    logic             m_rp;
    logic [TAG_W-1:0] m_rt;
    logic             m_err;

    flag_cond_unit #(.TAG_W(TAG_W), .PEND_W(PEND_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .flag_alloc    (flag_alloc),
        .alloc_ready   (alloc_ready),
        .flag_wr_valid (flag_wr_valid),
        .flag_wr_data  (flag_wr_data),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_cond      (req_cond),
        .req_tag       (req_tag),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_pass      (rsp_pass),
        .rsp_tag       (rsp_tag),
        .flags         (flags),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // Pairs of codes share a predicate; the odd member is its inverse.
    function automatic logic cond_ref(input logic [3:0] f, input logic [3:0] c);
        logic n, z, cf, v, base;
        int   pair;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        pair = int'(c) / 2;
        case (pair)
            0:       base = z;
            1:       base = cf;
            2:       base = n;
            3:       base = v;
            4:       base = cf && !z;
            5:       base = (n == v);
            6:       base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return (int'(c) % 2 == 1) ? !base : base;
    endfunction

    function automatic logic m_bypass();
`ifdef FLAG_BYPASS_EN
        return flag_wr_valid && (m_cnt == 1) && !flag_alloc;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic exp_req_ready();
        logic stalled;
        stalled = (m_cnt != 0) && !m_bypass();
        return !stalled && (!m_rv || rsp_ready);
    endfunction

    function automatic logic exp_alloc_ready();
        return m_cnt != PEND_MAX;
    endfunction

    // Advance the model with the current inputs, then clock the DUT.
    task automatic tick();
        logic       acc, aok, byp;
        logic [3:0] src;
        if (rst) begin
            m_flags = 4'h0; m_cnt = 0; m_rv = 1'b0; m_rp = 1'b0; m_rt = '0; m_err = 1'b0;
        end else begin
            acc = req_valid && exp_req_ready();
            aok = flag_alloc && exp_alloc_ready();
            byp = m_bypass();
            src = byp ? flag_wr_data : m_flags;
            if (acc) begin
                m_rv = 1'b1; m_rp = cond_ref(src, req_cond); m_rt = req_tag;
            end else if (rsp_ready) begin
                m_rv = 1'b0;
            end
            if (flag_wr_valid) m_flags = flag_wr_data;
            if (aok && flag_wr_valid) begin
                // alloc and write cancel
            end else if (aok) begin
                m_cnt++;
            end else if (flag_wr_valid) begin
                if (m_cnt > 0) m_cnt--;
                else m_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flag_alloc = 0; flag_wr_valid = 0; flag_wr_data = 0;
        req_valid = 0; req_cond = 0; req_tag = 0; rsp_ready = 1;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        tick(); tick();
        rst = 0;
        #1;
        n_checks++; if (flags !== 4'h0) begin n_fail++; $display("FAIL reset_flags: got %h required 0", flags); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
        n_checks++; if (rsp_pass !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_pass: got %b required 0", rsp_pass); end
        n_checks++; if (rsp_tag !== '0) begin n_fail++; $display("FAIL reset_rsp_tag: got %h required 0", rsp_tag); end
        n_checks++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_underflow: got %b required 0", underflow_err); end
        n_checks++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_alloc_ready: got %b required 1", alloc_ready); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b required 1", req_ready); end
    endtask

    task automatic test_first_request();
        req_valid = 1; req_cond = 4'd0; req_tag = 4'd3;
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL first_req_ready: got %b required 1", req_ready); end
        tick();
        req_valid = 0;
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL first_rsp_valid: got %b required 1", rsp_valid); end
        n_checks++; if (rsp_pass !== 1'b0) begin n_fail++; $display("FAIL first_rsp_pass: got %b required 0", rsp_pass); end
        n_checks++; if (rsp_tag !== 4'd3) begin n_fail++; $display("FAIL first_rsp_tag: got %h required 3", rsp_tag); end
        tick();
    endtask

    task automatic test_stall_release();
        int acc_at;
        int want_at;
`ifdef FLAG_BYPASS_EN
        want_at = 2;
`else
        want_at = 3;
`endif
        acc_at = -1;
        flag_alloc = 1;
        tick();
        flag_alloc = 0;
        req_valid = 1; req_cond = 4'd0; req_tag = 4'd5; flag_wr_data = 4'b0100;
        for (int i = 0; i < 10 && acc_at < 0; i++) begin
            flag_wr_valid = (i == 2);
            #1;
            n_checks++;
            if (req_ready !== exp_req_ready()) begin
                n_fail++; $display("FAIL stall_req_ready[%0d]: got %b required %b", i, req_ready, exp_req_ready());
            end
            if (req_ready === 1'b1) acc_at = i;
            tick();
        end
        req_valid = 0; flag_wr_valid = 0;
        n_checks++; if (acc_at != want_at) begin n_fail++; $display("FAIL stall_accept_cycle: got %0d required %0d", acc_at, want_at); end
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL stall_rsp_valid: got %b required 1", rsp_valid); end
        n_checks++; if (rsp_pass !== 1'b1) begin n_fail++; $display("FAIL stall_rsp_pass: got %b required 1", rsp_pass); end
        n_checks++; if (rsp_tag !== 4'd5) begin n_fail++; $display("FAIL stall_rsp_tag: got %h required 5", rsp_tag); end
        n_checks++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL stall_underflow: got %b required 0", underflow_err); end
        tick();
    endtask

    // Back-to-back sweep: flags loaded with a same-cycle alloc+write (count
    // stays 0), then all 16 codes issued on consecutive cycles.
    task automatic test_cond_sweep();
        for (int f = 0; f < 16; f++) begin
            flag_alloc = 1; flag_wr_valid = 1; flag_wr_data = 4'(f);
            tick();
            flag_alloc = 0; flag_wr_valid = 0;
            n_checks++; if (flags !== 4'(f)) begin n_fail++; $display("FAIL sweep_flags: got %h required %h", flags, 4'(f)); end
            for (int c = 0; c < 16; c++) begin
                req_valid = 1; req_cond = 4'(c); req_tag = 4'(c);
                #1;
                n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL sweep_req_ready f=%0d c=%0d: got %b required 1", f, c, req_ready); end
                tick();
                n_checks++;
                if (rsp_valid !== 1'b1 || rsp_pass !== cond_ref(4'(f), 4'(c)) || rsp_tag !== 4'(c)) begin
                    n_fail++;
                    $display("FAIL sweep_rsp f=%0d c=%0d: got v=%b p=%b t=%h required v=1 p=%b t=%h",
                             f, c, rsp_valid, rsp_pass, rsp_tag, cond_ref(4'(f), 4'(c)), 4'(c));
                end
            end
            req_valid = 0;
            tick();
        end
        n_checks++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL sweep_underflow: got %b required 0", underflow_err); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 8; i++) begin
            flag_alloc = 1;
            #1;
            n_checks++;
            if (alloc_ready !== (i < PEND_MAX)) begin
                n_fail++; $display("FAIL sat_alloc_ready[%0d]: got %b required %b", i, alloc_ready, (i < PEND_MAX));
            end
            tick();
        end
        flag_alloc = 0;
        // six writes leave one outstanding writer
        for (int i = 0; i < 6; i++) begin
            flag_wr_valid = 1; flag_wr_data = 4'($urandom_range(15));
            #1;
            n_checks++; if (alloc_ready !== exp_alloc_ready()) begin n_fail++; $display("FAIL sat_drain_alloc_ready[%0d]: got %b required %b", i, alloc_ready, exp_alloc_ready()); end
            tick();
        end
        flag_wr_valid = 0;
        #1;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL sat_one_left_req_ready: got %b required 0", req_ready); end
        flag_alloc = 1; flag_wr_valid = 1; flag_wr_data = 4'hA;
        tick();
        flag_alloc = 0; flag_wr_valid = 0;
        #1;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL sat_alloc_write_req_ready: got %b required 0", req_ready); end
        flag_wr_valid = 1; flag_wr_data = 4'h6;
        tick();
        flag_wr_valid = 0;
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL sat_drained_req_ready: got %b required 1", req_ready); end
        n_checks++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL sat_underflow: got %b required 0", underflow_err); end
        n_checks++; if (flags !== 4'h6) begin n_fail++; $display("FAIL sat_flags: got %h required 6", flags); end
    endtask

    task automatic test_backpressure();
        rsp_ready = 0;
        req_valid = 1; req_cond = 4'($urandom_range(15)); req_tag = 4'hA;
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_first_req_ready: got %b required 1", req_ready); end
        tick();
        req_cond = 4'($urandom_range(15)); req_tag = 4'hB;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_req_ready[%0d]: got %b required 0", i, req_ready); end
            tick();
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_pass !== m_rp || rsp_tag !== 4'hA) begin
                n_fail++; $display("FAIL bp_hold_rsp[%0d]: got v=%b p=%b t=%h required v=1 p=%b t=a", i, rsp_valid, rsp_pass, rsp_tag, m_rp);
            end
        end
        rsp_ready = 1;
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_req_ready: got %b required 1", req_ready); end
        tick();
        req_valid = 0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_pass !== m_rp || rsp_tag !== 4'hB) begin
            n_fail++; $display("FAIL bp_second_rsp: got v=%b p=%b t=%h required v=1 p=%b t=b", rsp_valid, rsp_pass, rsp_tag, m_rp);
        end
        tick();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b required 0", rsp_valid); end
    endtask

    task automatic test_underflow_and_reset();
        logic [3:0] d;
        d = 4'($urandom_range(15));
        flag_wr_valid = 1; flag_wr_data = d;
        tick();
        flag_wr_valid = 0;
        n_checks++; if (flags !== d) begin n_fail++; $display("FAIL uf_flags: got %h required %h", flags, d); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (underflow_err !== 1'b1) begin n_fail++; $display("FAIL uf_sticky[%0d]: got %b required 1", i, underflow_err); end
            tick();
        end
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL uf_count_zero: got %b required 1", req_ready); end
        // Park a response, then create a stall with two writers.
        rsp_ready = 0; req_valid = 1; req_cond = 4'd14; req_tag = 4'h7;
        tick();
        req_valid = 0; flag_alloc = 1;
        tick(); tick();
        flag_alloc = 0;
        // Reset with every input active; all of it must be ignored.
        rst = 1; flag_alloc = 1; flag_wr_valid = 1; flag_wr_data = 4'hF;
        req_valid = 1; rsp_ready = 1;
        tick();
        rst = 0; idle_inputs();
        #1;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
        n_checks++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL rst_underflow: got %b required 0", underflow_err); end
        n_checks++; if (flags !== 4'h0) begin n_fail++; $display("FAIL rst_flags: got %h required 0", flags); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_count_cleared: got %b required 1", req_ready); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst           = ($urandom_range(49) == 0);
            flag_alloc    = ($urandom_range(9) < 3);
            flag_wr_valid = ($urandom_range(9) < 3);
            flag_wr_data  = 4'($urandom_range(15));
            req_valid     = ($urandom_range(1) == 1);
            req_cond      = 4'($urandom_range(15));
            req_tag       = TAG_W'($urandom_range(15));
            rsp_ready     = ($urandom_range(9) < 7);
            #1;
            n_checks++; if (req_ready !== exp_req_ready()) begin n_fail++; $display("FAIL rand_req_ready[%0d]: got %b required %b", i, req_ready, exp_req_ready()); end
            n_checks++; if (alloc_ready !== exp_alloc_ready()) begin n_fail++; $display("FAIL rand_alloc_ready[%0d]: got %b required %b", i, alloc_ready, exp_alloc_ready()); end
            tick();
            n_checks++; if (rsp_valid !== m_rv) begin n_fail++; $display("FAIL rand_rsp_valid[%0d]: got %b required %b", i, rsp_valid, m_rv); end
            if (m_rv) begin
                n_checks++;
                if (rsp_pass !== m_rp || rsp_tag !== m_rt) begin
                    n_fail++; $display("FAIL rand_rsp[%0d]: got p=%b t=%h required p=%b t=%h", i, rsp_pass, rsp_tag, m_rp, m_rt);
                end
            end
            n_checks++; if (flags !== m_flags) begin n_fail++; $display("FAIL rand_flags[%0d]: got %h required %h", i, flags, m_flags); end
            n_checks++; if (underflow_err !== m_err) begin n_fail++; $display("FAIL rand_underflow[%0d]: got %b required %b", i, underflow_err, m_err); end
        end
        rst = 0; idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_first_request();
        test_stall_release();
        test_cond_sweep();
        test_saturation();
        test_backpressure();
        test_underflow_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_flag_cond_unit
